alu_issue_controller: RTL

Initiator-side sequencer driving the execute-stage ALU. It accepts decoded operations from the pipeline over a valid/ready handshake, and encodes each opcode into the ALU's functional-unit select (`alu_operation`) and sub-operation select (`alu_operation_select`). It holds registered operands for the unit's latency, then captures `alu_out`/`alu_flags` into a result buffer that is drained by writeback over a second valid/ready handshake.

---
 rtl/alu_issue_controller_pkg.sv | 31 +++
 rtl/alu_issue_controller_op_encoder.sv | 30 +++
 rtl/alu_issue_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_issue_controller_pkg.sv
// Shared constants, state encoding and result-width helper for the ALU issue controller.
package alu_issue_controller_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_RSVD = 3'b011;
   localparam logic [2:0] OP_SHL  = 3'b100;
   localparam logic [2:0] OP_SHR  = 3'b101;
   localparam logic [2:0] OP_AND  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   localparam logic [1:0] FU_ADD   = 2'b00;
   localparam logic [1:0] FU_MUL   = 2'b01;
   localparam logic [1:0] FU_SHIFT = 2'b10;
   localparam logic [1:0] FU_LOGIC = 2'b11;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Only the multiplier produces a 16-bit result; everything else is 8 bits zero-extended.
   function automatic logic [15:0] width_fix(input logic is_mul, input logic [15:0] raw);
      return is_mul ? raw : {8'h00, raw[7:0]};
   endfunction

endpackage

// File: rtl/alu_issue_controller_op_encoder.sv
// Combinational opcode encoder: functional-unit select, sub-operation select and op class.
module alu_op_encoder
   import alu_issue_controller_pkg::*;
(
   input  logic [2:0] i_opcode,
   output logic [1:0] o_alu_operation,
   output logic       o_alu_operation_select,
   output logic       o_is_mul,
   output logic       o_is_illegal
);

   always_comb begin
      o_alu_operation        = FU_ADD;
      o_alu_operation_select = i_opcode[0];
      o_is_mul               = 1'b0;
      o_is_illegal           = 1'b0;
      case (i_opcode)
         OP_ADD, OP_SUB: o_alu_operation = FU_ADD;
         OP_MUL: begin
            o_alu_operation = FU_MUL;
            o_is_mul        = 1'b1;
         end
         OP_RSVD: o_is_illegal = 1'b1;
         OP_SHL, OP_SHR: o_alu_operation = FU_SHIFT;
         OP_AND, OP_OR:  o_alu_operation = FU_LOGIC;
         default:        o_alu_operation = FU_ADD;
      endcase
   end

endmodule

// File: rtl/alu_issue_controller.sv
// Issue sequencer for the execute-stage ALU with a one-entry result buffer.
// Optional perf counters are enabled by defining ALU_ISSUE_PERF_COUNT_EN.
module alu_issue_controller
   import alu_issue_controller_pkg::*;
#(
   parameter int unsigned ALU_LATENCY = 1,
   parameter int unsigned MUL_LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   output logic        issue_ready,
   input  logic [2:0]  issue_opcode,
   input  logic [7:0]  issue_a,
   input  logic [7:0]  issue_b,
   input  logic [2:0]  issue_dest,
   output logic [1:0]  alu_operation,
   output logic        alu_operation_select,
   output logic [7:0]  top_operand,
   output logic [7:0]  bottom_operand,
   input  logic [2:0]  alu_flags,
   input  logic [15:0] alu_out,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [15:0] result_data,
   output logic [2:0]  result_flags,
   output logic [2:0]  result_dest,
   output logic        result_illegal
`ifdef ALU_ISSUE_PERF_COUNT_EN
   ,
   output logic [15:0] perf_issued,
   output logic [15:0] perf_stall
`endif
);

   localparam logic [CNT_W-1:0] ALU_CNT = CNT_W'(ALU_LATENCY - 1);
   localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LATENCY - 1);

   state_e           r_state;
   logic [CNT_W-1:0] r_count;
   logic             r_is_mul;
   logic [2:0]       r_dest;

   logic [1:0]       w_fu;
   logic             w_sel;
   logic             w_is_mul;
   logic             w_is_illegal;
   logic             w_accept;

   alu_op_encoder u_enc (
      .i_opcode               (issue_opcode),
      .o_alu_operation        (w_fu),
      .o_alu_operation_select (w_sel),
      .o_is_mul               (w_is_mul),
      .o_is_illegal           (w_is_illegal)
   );

   assign w_accept = issue_valid & issue_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state              <= ST_IDLE;
         r_count              <= '0;
         r_is_mul             <= 1'b0;
         r_dest               <= '0;
         issue_ready          <= 1'b0;
         alu_operation        <= FU_ADD;
         alu_operation_select <= 1'b0;
         top_operand          <= '0;
         bottom_operand       <= '0;
         result_valid         <= 1'b0;
         result_data          <= '0;
         result_flags         <= '0;
         result_dest          <= '0;
         result_illegal       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  issue_ready          <= 1'b0;
                  top_operand          <= issue_a;
                  bottom_operand       <= issue_b;
                  alu_operation        <= w_fu;
                  alu_operation_select <= w_sel;
                  r_is_mul             <= w_is_mul;
                  r_dest               <= issue_dest;
                  // Reserved opcode bypasses the ALU and posts a zero result immediately.
                  if (w_is_illegal) begin
                     result_valid   <= 1'b1;
                     result_data    <= '0;
                     result_flags   <= '0;
                     result_dest    <= issue_dest;
                     result_illegal <= 1'b1;
                     r_state        <= ST_DONE;
                  end else begin
                     r_count <= w_is_mul ? MUL_CNT : ALU_CNT;
                     r_state <= ST_EXEC;
                  end
               end else begin
                  issue_ready <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (r_count == '0) begin
                  result_valid   <= 1'b1;
                  result_data    <= width_fix(r_is_mul, alu_out);
                  result_flags   <= alu_flags;
                  result_dest    <= r_dest;
                  result_illegal <= 1'b0;
                  r_state        <= ST_DONE;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            ST_DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  issue_ready  <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               issue_ready <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_ISSUE_PERF_COUNT_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_issued <= '0;
         perf_stall  <= '0;
      end else begin
         if (w_accept)
            perf_issued <= perf_issued + 16'd1;
         if (r_state == ST_DONE && !result_ready)
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule
